// File: rtl/afifo_read_drain_pkg.sv
// Shared constants and FSM encoding for the async-FIFO read-side drain block.
// Imported by the skid buffer and the top level.
package afifo_read_drain_pkg;

  localparam int OCC_W     = 2;
  localparam int BUF_DEPTH = 2;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/afifo_read_drain_rd_skid_buf.sv
// Two-entry in-order output buffer: head is presented on the stream, tail absorbs
// the word arriving while the head is stalled.
module rd_skid_buf
  import afifo_read_drain_pkg::*;
#(
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  wr,
  input  logic [data_width-1:0] wdata,
  input  logic                  rd,
  output logic [data_width-1:0] head,
  output logic [OCC_W-1:0]      occ,
  output logic                  valid
);

  logic [data_width-1:0] tail;
  logic                  do_rd;
  logic                  do_wr;
  logic                  tail_we;

  assign do_rd = rd & (occ != '0);
  assign do_wr = wr & ((occ != OCC_W'(BUF_DEPTH)) | do_rd);
  assign valid = (occ != '0);

  // The tail only takes the new word when the head stays occupied after this edge.
  assign tail_we = do_wr & (((occ == OCC_W'(1)) & ~do_rd) |
                            ((occ == OCC_W'(BUF_DEPTH)) & do_rd));

  always_ff @(posedge clk) begin
    if (clr) begin
      occ  <= '0;
      head <= '0;
    end else if (do_rd && do_wr) begin
      head <= (occ == OCC_W'(1)) ? wdata : tail;
    end else if (do_rd) begin
      if (occ == OCC_W'(BUF_DEPTH)) head <= tail;
      occ <= occ - OCC_W'(1);
    end else if (do_wr) begin
      if (occ == '0) head <= wdata;
      occ <= occ + OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (tail_we) tail <= wdata;
  end

endmodule

// File: rtl/afifo_read_drain.sv
// Read-side consumer for the async FIFO: issues reads, hides the 1-cycle r_data
// latency behind a 2-entry buffer and delivers words on a valid/ready stream.
module afifo_read_drain
  import afifo_read_drain_pkg::*;
#(
  parameter int data_width  = 8,
  parameter int count_width = 16
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   enable,
  input  logic                   fifo_empty,
  input  logic [data_width-1:0]  fifo_rdata,
  output logic                   fifo_read_en,
  output logic [data_width-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   busy,
  output logic [count_width-1:0] xfer_count
);

  state_t           state;
  logic             inflight;
  logic             pop;
  logic             accept;
  logic [OCC_W-1:0] occ;
  logic [OCC_W:0]   held;

  assign pop = m_valid & m_ready;

  // Words committed to the buffer after this edge; forwarding pop keeps full rate.
  assign held = {1'b0, occ} + (OCC_W + 1)'(inflight) - (OCC_W + 1)'(pop);

  assign fifo_read_en = ~clr & (state == ST_RUN) & ~fifo_empty &
                        (held < (OCC_W + 1)'(BUF_DEPTH));
  assign accept       = fifo_read_en & ~fifo_empty;
  assign busy         = inflight | (occ != '0);

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= ST_STOP;
      inflight   <= 1'b0;
      xfer_count <= '0;
    end else begin
      state    <= enable ? ST_RUN : ST_STOP;
      inflight <= accept;
      if (pop) xfer_count <= xfer_count + {{(count_width - 1){1'b0}}, 1'b1};
    end
  end

  rd_skid_buf #(
    .data_width(data_width)
  ) u_buf (
    .clk  (clk),
    .clr  (clr),
    .wr   (inflight),
    .wdata(fifo_rdata),
    .rd   (pop),
    .head (m_data),
    .occ  (occ),
    .valid(m_valid)
  );

endmodule

// File: tb/tb_afifo_read_drain.sv
// Bench for afifo_read_drain: FIFO model, queue-based stream reference and directed tables.
module tb_afifo_read_drain;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        enable = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_rdata = 8'h00;
  logic        m_ready = 1'b0;
  logic        fifo_read_en;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        busy;
  logic [15:0] xfer_count;
  logic        w_read_en, w_valid, w_busy;
  logic [7:0]  w_data;
  logic [3:0]  w_count;

  always #5 clk = ~clk;

  afifo_read_drain #(.data_width(8), .count_width(16)) dut (
    .clk(clk), .clr(clr), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .fifo_read_en(fifo_read_en), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .xfer_count(xfer_count)
  );

  afifo_read_drain #(.data_width(8), .count_width(4)) u_wrap (
    .clk(clk), .clr(clr), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .fifo_read_en(w_read_en), .m_data(w_data),
    .m_valid(w_valid), .m_ready(m_ready), .busy(w_busy), .xfer_count(w_count)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  fifo_q[$];
  logic [7:0]  dut_out[$];

  bit          m_run;
  bit          m_infl;
  logic [7:0]  m_buf[$];
  logic [7:0]  m_last;
  int unsigned m_cnt;

  logic        obs_re, obs_acc, obs_valid, obs_busy;
  logic [7:0]  obs_data;
  logic [15:0] obs_cnt;
  logic [3:0]  obs_wcnt;

  typedef struct {
    logic       en;
    logic       rdy;
    logic       re;
    logic       vld;
    logic [7:0] data;
    logic [15:0] cnt;
    logic       bsy;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fifo_reset();
    fifo_q.delete();
    dut_out.delete();
  endtask

  // One clock: drive inputs, check against the reference at negedge, advance at posedge.
  task automatic tick(input logic c, input logic e, input logic r);
    logic       exp_valid, exp_re, exp_busy, pop_m;
    logic [7:0] exp_data, cap;
    clr = c; enable = e; m_ready = r;
    fifo_empty = (fifo_q.size() == 0);
    @(negedge clk);
    exp_valid = (m_buf.size() != 0);
    exp_data  = exp_valid ? m_buf[0] : m_last;
    pop_m     = exp_valid & r;
    exp_busy  = m_infl | exp_valid;
    exp_re    = !c && m_run && (fifo_q.size() != 0) &&
                (int'(m_buf.size()) + int'(m_infl) - int'(pop_m) < 2);
    chk("read_en", fifo_read_en, exp_re);
    chk("m_valid", m_valid, exp_valid);
    chk("m_data", m_data, exp_data);
    chk("busy", busy, exp_busy);
    chk("xfer_count", xfer_count, m_cnt[15:0]);
    chk("xfer_count_w4", w_count, m_cnt[3:0]);
    obs_re = fifo_read_en; obs_valid = m_valid; obs_data = m_data;
    obs_busy = busy; obs_cnt = xfer_count; obs_wcnt = w_count;
    obs_acc = fifo_read_en & !fifo_empty;
    if (m_valid && r && !c) dut_out.push_back(m_data);
    @(posedge clk);
    #1;
    cap = fifo_rdata;
    if (c) begin
      m_run = 0; m_infl = 0; m_buf.delete(); m_last = 8'h00; m_cnt = 0;
    end else begin
      if (pop_m) begin
        m_last = m_buf.pop_front();
        m_cnt++;
      end
      if (m_infl) m_buf.push_back(cap);
      if (m_buf.size() > 2) chk("buffer_overflow", m_buf.size(), 2);
      m_infl = obs_acc;
      m_run  = e;
    end
    if (obs_acc && fifo_q.size() != 0) fifo_rdata = fifo_q.pop_front();
    else fifo_rdata = 8'($urandom);
  endtask

  vec_t tbl[12];
  int   acc_n;
  int   budget;
  logic [15:0] c0;

  initial begin
    // Streaming of 0x01..0x08 at full rate, starting from STOP.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0, 1'b1};
    for (int k = 3; k <= 8; k++)
      tbl[k] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'(k - 2), 16'(k - 3), 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 16'd6, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h08, 16'd7, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h08, 16'd8, 1'b0};

    m_run = 0; m_infl = 0; m_last = 8'h00; m_cnt = 0;
    @(posedge clk);
    #1;

    // Reset with a non-empty FIFO
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'hA0 + 8'(i));
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b1, 1'b1);
      chk("reset_read_en", obs_re, 1'b0);
      chk("reset_valid", obs_valid, 1'b0);
      chk("reset_busy", obs_busy, 1'b0);
    end
    fifo_reset();

    // Streaming table
    for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, tbl[i].en, tbl[i].rdy);
      chk($sformatf("tbl%0d_re", i), obs_re, tbl[i].re);
      chk($sformatf("tbl%0d_vld", i), obs_valid, tbl[i].vld);
      chk($sformatf("tbl%0d_data", i), obs_data, tbl[i].data);
      chk($sformatf("tbl%0d_cnt", i), obs_cnt, tbl[i].cnt);
      chk($sformatf("tbl%0d_busy", i), obs_busy, tbl[i].bsy);
    end

    // Backpressure: stalled from the start, then stalled mid-stream
    tick(1'b1, 1'b0, 1'b0);
    fifo_reset();
    for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
    acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      acc_n += int'(obs_acc);
    end
    chk("stall_accepts", acc_n, 2);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1);
    acc_n = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      acc_n += int'(obs_acc);
    end
    chk("midstall_accepts", acc_n, 0);
    budget = 0;
    while (dut_out.size() < 8 && budget < 40) begin
      tick(1'b0, 1'b1, $urandom_range(0, 1) == 1);
      budget++;
    end
    chk("bp_count", dut_out.size(), 8);
    for (int i = 0; i < 8 && i < dut_out.size(); i++)
      chk($sformatf("bp_order%0d", i), dut_out[i], 8'(i + 1));

    // Empty gap then refill
    tick(1'b1, 1'b0, 1'b0);
    fifo_reset();
    for (int i = 1; i <= 3; i++) fifo_q.push_back(8'(i));
    budget = 0;
    while (dut_out.size() < 3 && budget < 20) begin
      tick(1'b0, 1'b1, 1'b1);
      budget++;
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b1);
      chk("gap_read_en", obs_re, 1'b0);
    end
    chk("gap_valid", obs_valid, 1'b0);
    fifo_q.push_back(8'h04);
    budget = 0;
    while (dut_out.size() < 4 && budget < 10) begin
      tick(1'b0, 1'b1, 1'b1);
      budget++;
    end
    chk("gap_count", dut_out.size(), 4);
    if (dut_out.size() >= 4) chk("gap_word", dut_out[3], 8'h04);

    // Stop and drain with one word buffered and one in flight
    tick(1'b1, 1'b0, 1'b0);
    fifo_reset();
    for (int i = 1; i <= 10; i++) fifo_q.push_back(8'h10 + 8'(i));
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    c0 = obs_cnt;
    acc_n = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      acc_n += int'(obs_re);
      if (i == 0) c0 = obs_cnt;
    end
    chk("drain_reads", acc_n, 0);
    chk("drain_words", obs_cnt - c0, 16'd2);
    chk("drain_busy", obs_busy, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    chk("resume_read_en", obs_re, 1'b1);

    // Counter wrap on the 4-bit instance, then reset mid-stream
    tick(1'b1, 1'b0, 1'b0);
    fifo_reset();
    for (int i = 0; i < 24; i++) fifo_q.push_back(8'h40 + 8'(i));
    budget = 0;
    while (m_cnt < 14 && budget < 40) begin
      tick(1'b0, 1'b1, 1'b1);
      budget++;
    end
    tick(1'b0, 1'b1, 1'b0);
    chk("wrap_pre", obs_wcnt, 4'hE);
    budget = 0;
    while (m_cnt < 17 && budget < 20) begin
      tick(1'b0, 1'b1, 1'b1);
      budget++;
    end
    tick(1'b0, 1'b1, 1'b0);
    chk("wrap_post", obs_wcnt, 4'h1);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    chk("clr_valid", obs_valid, 1'b0);
    chk("clr_data", obs_data, 8'h00);
    chk("clr_busy", obs_busy, 1'b0);
    chk("clr_count", obs_cnt, 16'h0000);
    chk("clr_read_en", obs_re, 1'b0);

    // Randomized traffic
    tick(1'b1, 1'b0, 1'b0);
    fifo_reset();
    for (int i = 0; i < 1500; i++) begin
      if (fifo_q.size() < 16 && $urandom_range(0, 1) == 1) fifo_q.push_back(8'($urandom));
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
